// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Bridges a cache that moves whole 256-bit lines to a memory that moves
// 64-bit beats. A line read is assembled from four beats, and a line write is
// split into four beats. Each beat is acknowledged by the memory with resp_i.
// Memory may insert gap cycles (resp_i=0) between beats.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   address_i  line address from the cache
//   read_i     line-read request (level, held until resp_o)
//   write_i    line-write request (level, held until resp_o); wins over read_i
//   line_i     line to write, from the cache
//   line_o     assembled read line to the cache (held between reads)
//   resp_o     one-cycle completion pulse to the cache
//   address_o  burst address to memory (0 while idle)
//   read_o     burst-read request to memory
//   write_o    burst-write request to memory
//   burst_o    write beat data to memory (0 outside a write)
//   burst_i    read beat data from memory, valid when resp_i=1
//   resp_i     per-beat acknowledge from memory
//
// Configuration macro
//   ADAPTOR_ADDR_ALIGN_EN  when defined, address_o[4:0] is forced to zero so
//                          the memory always sees a 32-byte aligned line
//                          address; when undefined the latched address is
//                          passed through unmodified.
// -----------------------------------------------------------------------------
module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    output logic         resp_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    output logic [63:0]  burst_o,
    input  logic [63:0]  burst_i,
    input  logic         resp_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [1:0]    r_cnt;
    logic [1:0]    w_cnt_next;
    logic [31:0]   r_addr;
    logic [31:0]   w_addr_next;
    logic [255:0]  r_line;
    logic [255:0]  w_line_next;

    // Output flags are registered from the next state so that read_o,
    // write_o and resp_o come straight from flops.
    logic          r_read;
    logic          r_write;
    logic          r_resp;

    logic          w_capture;
    logic [31:0]   w_addr_out;
    logic [63:0]   w_wslice [4];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_line_next  = r_line;

        unique case (r_state)
            ST_IDLE: begin
                // Write is checked first so it wins a simultaneous read.
                if (write_i) begin
                    w_addr_next  = address_i;
                    w_line_next  = line_i;
                    w_cnt_next   = 2'd0;
                    w_state_next = ST_WRITE;
                end else if (read_i) begin
                    w_addr_next  = address_i;
                    w_cnt_next   = 2'd0;
                    w_state_next = ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (resp_i) begin
                    // The 2-bit counter wraps 3 -> 0 on the final beat.
                    w_cnt_next = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and latched-request registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= '0;
            r_line  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_line  <= w_line_next;
            r_read  <= (w_state_next == ST_READ);
            r_write <= (w_state_next == ST_WRITE);
            r_resp  <= (w_state_next == ST_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Read-line assembly and write-line slicing, one 64-bit lane per beat
    // -------------------------------------------------------------------------
    assign w_capture = (r_state == ST_READ) && resp_i;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [63:0] r_beat;

        // Lane gi captures only on the beat whose index matches the counter;
        // gap cycles and writes leave it untouched, so line_o holds between
        // reads.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_beat <= '0;
            end else if (w_capture && (r_cnt == 2'(gi))) begin
                r_beat <= burst_i;
            end
        end

        assign line_o[64*gi +: 64] = r_beat;
        assign w_wslice[gi]        = r_line[64*gi +: 64];
    end

    // -------------------------------------------------------------------------
    // Memory-side outputs
    // -------------------------------------------------------------------------
`ifdef ADAPTOR_ADDR_ALIGN_EN
    assign w_addr_out = {r_addr[31:5], 5'b0_0000};
`else
    assign w_addr_out = r_addr;
`endif

    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;
    assign address_o = (r_read || r_write) ? w_addr_out : 32'd0;
    assign burst_o   = r_write ? w_wslice[r_cnt] : 64'd0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Directed bench for cacheline_adaptor. Inputs are driven 1 ns after the
// rising edge and outputs are sampled at that same point, well away from the
// active edge. Every expected value below is a hand-written constant.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int n_tests = 0;
    int n_fail  = 0;
    int resp_pulses = 0;
    int read_hi_cycles = 0;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    // Cycle-accurate monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (resp_o === 1'b1) resp_pulses++;
        if (read_o === 1'b1) read_hi_cycles++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef ADAPTOR_ADDR_ALIGN_EN
        return {a[31:5], 5'b0_0000};
`else
        return a;
`endif
    endfunction

    // Drives memory acknowledges with the given gap pattern (LSB first; ones
    // after plen) until resp_o appears or the cycle budget runs out. cycles
    // returns the number of memory cycles up to and including the last beat.
    task automatic run_beats(input logic [63:0] b0, input logic [63:0] b1,
                             input logic [63:0] b2, input logic [63:0] b3,
                             input logic [15:0] pat, input int plen,
                             input logic [31:0] ea, input bit is_write,
                             input logic [255:0] wl, output int cycles);
        logic [63:0] beats [4];
        int k;
        bit done;
        beats  = '{b0, b1, b2, b3};
        k      = 0;
        done   = 1'b0;
        cycles = 0;
        while (!done && cycles < 32) begin
            resp_i  = (cycles < plen) ? pat[cycles] : 1'b1;
            burst_i = resp_i ? beats[(k < 4) ? k : 0] : 64'hBAD0_BAD0_BAD0_BAD0;
            // Request-side inputs wander mid-transaction; they must be ignored.
            address_i = $urandom;
            line_i    = {8{$urandom}};
            check("busy_addr", address_o, exp_addr(ea));
            if (is_write) begin
                check("wr_burst", burst_o, wl[64*((k < 4) ? k : 0) +: 64]);
            end
            if (resp_i) k++;
            tick();
            cycles++;
            if (resp_o === 1'b1) done = 1'b1;
        end
        resp_i  = 1'b0;
        burst_i = '0;
        check("resp_seen", done, 1'b1);
    endtask

    // Full read. exp_edges counts clock edges from asserting read_i to the
    // edge that raises resp_o. With hold=1 read_i stays high after DONE.
    task automatic do_read(input logic [31:0] addr,
                           input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3,
                           input logic [15:0] pat, input int plen,
                           input logic [255:0] exp_line, input int exp_edges,
                           input bit hold);
        int p0;
        int cyc;
        p0 = resp_pulses;
        address_i = addr;
        read_i    = 1'b1;
        write_i   = 1'b0;
        tick();
        check("rd_read_o", read_o, 1'b1);
        check("rd_write_o", write_o, 1'b0);
        check("rd_addr", address_o, exp_addr(addr));
        run_beats(b0, b1, b2, b3, pat, plen, addr, 1'b0, '0, cyc);
        check("rd_latency", cyc + 1, exp_edges);
        check("rd_line", line_o, exp_line);
        check("rd_read_o_off", read_o, 1'b0);
        if (!hold) read_i = 1'b0;
        tick();
        check("rd_resp_drop", resp_o, 1'b0);
        check("rd_addr_idle", address_o, 32'd0);
        check("rd_one_pulse", resp_pulses - p0, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input bit also_read, input logic [255:0] exp_line_o);
        int p0;
        int r0;
        int cyc;
        p0 = resp_pulses;
        r0 = read_hi_cycles;
        address_i = addr;
        line_i    = line;
        write_i   = 1'b1;
        read_i    = also_read;
        tick();
        check("wr_write_o", write_o, 1'b1);
        check("wr_read_o", read_o, 1'b0);
        run_beats('0, '0, '0, '0, 16'hFFFF, 4, addr, 1'b1, line, cyc);
        check("wr_beats", cyc, 4);
        check("wr_write_o_off", write_o, 1'b0);
        check("wr_line_o_kept", line_o, exp_line_o);
        write_i = 1'b0;
        read_i  = 1'b0;
        tick();
        check("wr_burst_idle", burst_o, 64'd0);
        check("wr_one_pulse", resp_pulses - p0, 1);
        check("wr_no_read_o", read_hi_cycles - r0, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [255:0] l1;
        logic [255:0] l2;
        logic [255:0] l3;
        int p0;
        int cyc;

        rst       = 1'b1;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        line_i    = '0;
        burst_i   = '0;
        resp_i    = 1'b0;

        // Reset values, observed before any clock edge.
        #3;
        check("rst_line_o", line_o, 256'd0);
        check("rst_resp_o", resp_o, 1'b0);
        check("rst_read_o", read_o, 1'b0);
        check("rst_write_o", write_o, 1'b0);
        check("rst_addr", address_o, 32'd0);
        check("rst_burst", burst_o, 64'd0);
        tick();
        @(negedge clk) rst = 1'b0;
        tick();

        // Gap-free read: accept edge + 4 beat edges, resp_o in the 6th cycle.
        l1 = {64'h44, 64'h33, 64'h22, 64'h11};
        do_read(32'h4000_8040, 64'h11, 64'h22, 64'h33, 64'h44, 16'hFFFF, 4, l1, 5, 1'b0);

        // Memory acknowledges while idle are ignored.
        resp_i  = 1'b1;
        burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        check("idle_resp_read_o", read_o, 1'b0);
        check("idle_resp_resp_o", resp_o, 1'b0);
        check("idle_resp_line", line_o, l1);
        resp_i  = 1'b0;
        burst_i = '0;

        // Write: beats 0xA,0xB,0xC,0xD in order, line_o untouched.
        do_write(32'h4001_8040, {64'hD, 64'hC, 64'hB, 64'hA}, 1'b0, l1);

        // Gapped read, pattern 1,0,0,1,1,0,1 (LSB first = 7'b1011001).
        l2 = {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
              64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
        do_read(32'h4000_9000, 64'hA1A1_0000_0000_0001, 64'hA2A2_0000_0000_0002,
                64'hA3A3_0000_0000_0003, 64'hA4A4_0000_0000_0004,
                16'h0059, 7, l2, 8, 1'b0);

        // Simultaneous read and write: the write wins, read_o never rises.
        do_write(32'h4002_8040, {64'h1234_0000_0000_0004, 64'h1234_0000_0000_0003,
                                 64'h1234_0000_0000_0002, 64'h1234_0000_0000_0001},
                 1'b1, l2);

        // Reset after two read beats: everything clears at once, no resp_o.
        p0 = resp_pulses;
        address_i = 32'h4004_8040;
        read_i    = 1'b1;
        tick();
        resp_i  = 1'b1;
        burst_i = 64'h55;
        tick();
        burst_i = 64'h66;
        tick();
        resp_i  = 1'b0;
        burst_i = '0;
        #2 rst = 1'b1;
        #1;
        check("arst_read_o", read_o, 1'b0);
        check("arst_addr", address_o, 32'd0);
        check("arst_line_o", line_o, 256'd0);
        check("arst_resp_o", resp_o, 1'b0);
        read_i = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick();
        tick();
        check("arst_no_resp", resp_pulses - p0, 0);

        l3 = {64'h0C0C, 64'h0B0B, 64'h0A0A, 64'h0909};
        do_read(32'h4003_8040, 64'h0909, 64'h0A0A, 64'h0B0B, 64'h0C0C, 16'hFFFF, 4, l3, 5, 1'b0);

        // Unaligned address: passes through or is aligned depending on build.
        do_read(32'h4000_8042, 64'h1, 64'h2, 64'h3, 64'h4, 16'hFFFF, 4,
                {64'h4, 64'h3, 64'h2, 64'h1}, 5, 1'b0);

        // Request still held after DONE is taken as a new transaction.
        do_read(32'h4005_0000, 64'h7, 64'h8, 64'h9, 64'hA, 16'hFFFF, 4,
                {64'hA, 64'h9, 64'h8, 64'h7}, 5, 1'b1);
        address_i = 32'h4006_0000;
        tick();
        check("b2b_read_o", read_o, 1'b1);
        check("b2b_addr", address_o, exp_addr(32'h4006_0000));
        run_beats(64'hF1, 64'hF2, 64'hF3, 64'hF4, 16'hFFFF, 4, 32'h4006_0000, 1'b0, '0, cyc);
        check("b2b_beats", cyc, 4);
        check("b2b_line", line_o, {64'hF4, 64'hF3, 64'hF2, 64'hF1});
        read_i = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The block SHALL have no parameters: line width 256 bits, burst width 64 bits, 4 beats per line, all fixed.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 address_i  input  32  line address from cache (pmem_address).
REQ-005 read_i  input  1  line-read request from cache (pmem_read), level, held until resp_o.
REQ-006 write_i  input  1  line-write request from cache (pmem_write), level, held until resp_o.
REQ-007 line_i  input  256  write line from cache (pmem_wdata).
REQ-008 line_o  output  256  assembled read line to cache (pmem_rdata).
REQ-009 resp_o  output  1  one-cycle completion pulse to cache (pmem_resp).
REQ-010 address_o  output  32  burst address to memory.
REQ-011 read_o  output  1  burst-read request to memory.
REQ-012 write_o  output  1  burst-write request to memory.
REQ-013 burst_o  output  64  write beat data to memory.
REQ-014 burst_i  input  64  read beat data from memory, valid when resp_i=1.
REQ-015 resp_i  input  1  per-beat acknowledge from memory.

Function
REQ-016 The FSM SHALL have states IDLE, READ, WRITE, DONE; a 2-bit beat counter SHALL index beats 0..3.
REQ-017 In IDLE with write_i=1, the FSM SHALL latch address_i and line_i, clear the counter, and enter WRITE; write_i SHALL take priority over a simultaneous read_i.
REQ-018 In IDLE with read_i=1 and write_i=0, the FSM SHALL latch address_i, clear the counter, and enter READ.
REQ-019 read_o SHALL equal 1 exactly while in READ; write_o SHALL equal 1 exactly while in WRITE; both SHALL be registered, first high the cycle after acceptance.
REQ-020 address_o SHALL show the latched address throughout READ/WRITE and 0 otherwise.
REQ-021 In READ, each cycle with resp_i=1 SHALL capture burst_i into line_o[64k+63:64k] (k = counter) and increment the counter; resp_i=0 cycles SHALL be gaps with no capture.
REQ-022 In WRITE, burst_o SHALL show latched line slice k; each resp_i=1 SHALL advance k; burst_o SHALL be 0 outside WRITE.
REQ-023 The 4th accepted beat (k=3 with resp_i=1) SHALL move the FSM to DONE; the counter SHALL wrap to 0.
REQ-024 resp_o SHALL be 1 for exactly one cycle, in DONE, which SHALL return to IDLE unconditionally.
REQ-025 Read-to-resp_o latency SHALL be 1 cycle (accept) + the memory beat cycles + 1 cycle (DONE); with gap-free beats starting the cycle after read_o rises, 6 cycles total.
REQ-026 line_o SHALL hold its value between reads; a write SHALL NOT modify line_o.
REQ-027 read_i/write_i/address_i/line_i changes while not in IDLE SHALL be ignored.
REQ-028 resp_i in IDLE or DONE SHALL be ignored.
REQ-029 A request still asserted in the IDLE cycle after DONE SHALL be accepted as a new transaction.

Reset
REQ-030 rst=1 SHALL immediately, independent of clk, force IDLE, counter 0, latched address/line 0, line_o 0, resp_o 0, read_o 0, write_o 0, address_o 0, burst_o 0.
REQ-031 Reset mid-burst SHALL abandon the transaction with no resp_o; the first request after reset release SHALL be accepted normally.

Configuration
REQ-032 Macro ADAPTOR_ADDR_ALIGN_EN: when defined, address_o[4:0] SHALL be forced to 0 (32-byte line alignment); when undefined, address_o SHALL equal the latched address_i unmodified.

Verification
REQ-033 Read 0x40008040, memory returns beats 0x11,0x22,0x33,0x44 gap-free -> line_o = {0x44,0x33,0x22,0x11} in 64-bit slices, resp_o single pulse 6 cycles after read_i.
REQ-034 Write 0x40018040 with line_i = {0xD,0xC,0xB,0xA} -> burst_o presents 0xA,0xB,0xC,0xD on successive resp_i; write_o drops after 4th; resp_o one pulse; line_o unchanged.
REQ-035 Read with resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 captures in order; resp_o one cycle after final beat.
REQ-036 read_i=write_i=1 at 0x40028040 -> write performed, read_o never asserted.
REQ-037 rst pulse after 2 read beats -> all outputs 0 asynchronously, no resp_o; next read 0x40038040 completes with correct data.
REQ-038 Address 0x40008042 with ADAPTOR_ADDR_ALIGN_EN defined -> address_o = 0x40008040; undefined -> 0x40008042.
